win_capture: RTL
================

WIN_CAPTURE -- requirements
Module: win_capture

Interface
REQ-001 SHALL have parameter PIX_W, default 12, meaning pixel data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning output FIFO entries (power of two, >=4).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port vsync_start  input  1  high once the sync timing is running; capture is enabled only while high.
REQ-006 SHALL have port vref  input  1  vertical window qualifier.
REQ-007 SHALL have port href  input  1  horizontal window qualifier.
REQ-008 SHALL have port pix_in  input  PIX_W  pixel data, valid in cycles where vref&href=1.
REQ-009 SHALL have port m_data  output  PIX_W  output pixel.
REQ-010 SHALL have port m_sof  output  1  marks first pixel of a frame.
REQ-011 SHALL have port m_eol  output  1  marks last pixel of a line.
REQ-012 SHALL have port m_valid  output  1  output beat valid.
REQ-013 SHALL have port m_ready  input  1  consumer accepts beat.
REQ-014 SHALL have port ovf  output  1  sticky overflow flag, cleared only by reset.
REQ-015 SHALL have port line_cnt  output  12  lines captured in last completed frame.
REQ-016 SHALL have port pix_cnt  output  12  pixels in last completed line.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_V, FRAME, DROP.
REQ-018 SHALL: IDLE -> WAIT_V when vsync_start=1; any state -> IDLE when vsync_start=0.
REQ-019 SHALL: WAIT_V -> FRAME on first cycle with vref=0 followed by vref=1 (rising edge); capture never starts mid-window.
REQ-020 SHALL in FRAME capture pix_in each cycle vref&href=1 into a one-entry hold register with flags sof/eol.
REQ-021 SHALL push the held pixel to the FIFO when next qualified pixel arrives (eol=0) or when href falls (eol=1); write latency from pix_in to FIFO = 2 cycles.
REQ-022 SHALL set sof=1 on the first qualified pixel after entering FRAME only.
REQ-023 SHALL on vref falling in FRAME flush a held pixel with eol=1, latch line_cnt, return to WAIT_V.
REQ-024 SHALL count pixels per line (12-bit, saturating at 4095) and latch into pix_cnt at each eol push.
REQ-025 SHALL count lines (12-bit, saturating) incremented at each eol push, cleared at frame start.
REQ-026 SHALL on a push with FIFO full: discard the beat, set ovf, enter DROP.
REQ-027 SHALL in DROP discard all pixels; DROP -> WAIT_V on vref falling; line_cnt not updated for that frame.
REQ-028 SHALL present m_valid=1 whenever FIFO non-empty; beat transfers when m_valid&m_ready.
REQ-029 SHALL hold m_data/m_sof/m_eol stable while m_valid=1 and m_ready=0.
REQ-030 SHALL allow simultaneous push and pop when full (pop frees entry, push succeeds, no overflow).
REQ-031 SHALL allow simultaneous push and pop when empty without bypass (data appears next cycle).

Reset
REQ-032 SHALL on rst=1: state IDLE, FIFO empty, m_valid=0, m_data=0, m_sof=0, m_eol=0, ovf=0, line_cnt=0, pix_cnt=0, hold register empty.
REQ-033 SHALL on rst asserted mid-frame discard all in-flight data; after release wait for next vref rising edge.

Structure
REQ-034 SHALL place PIX_W default, counter width 12 and state encoding in shared package video_pkg.
REQ-035 SHALL instantiate one sub-module sync_fifo (width PIX_W+2, depth FIFO_DEPTH, full/empty outputs).

Verification
REQ-036 SHALL test: 4 lines x 8 pixels, m_ready=1 -> 32 beats, sof on beat 0, eol on beats 7/15/23/31, line_cnt=4, pix_cnt=8.
REQ-037 SHALL test: vsync_start rises while vref=1 -> no beats until next vref rising edge.
REQ-038 SHALL test: m_ready=0 for a 20-pixel line, depth 16 -> ovf=1, 16 beats held, rest of frame dropped, line_cnt unchanged.
REQ-039 SHALL test: FIFO full with m_ready=1 and push same cycle -> no ovf, count stays 16.
REQ-040 SHALL test: 1-pixel line -> single beat with eol=1 (and sof=1 if first line), pix_cnt=1.
REQ-041 SHALL test: rst pulse mid-line -> m_valid=0 next cycle, ovf=0, capture resumes on following frame.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants for the video capture path: default pixel width, counter
// width, capture FSM encoding and a saturating counter helper.
package video_pkg;

  localparam int PIX_W_DEF = 12;
  localparam int CNT_W     = 12;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT_V = 2'd1;
  localparam logic [1:0] ST_FRAME  = 2'd2;
  localparam logic [1:0] ST_DROP   = 2'd3;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; a write is accepted when full
// only if a read happens in the same cycle. No read-through bypass.
module sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd    = rd_en & ~empty;
  assign w_wr    = wr_en & (~full | w_rd);
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/win_capture.sv
// Captures pixels inside the vref/href window into a stream with sof/eol
// flags, buffered by an output FIFO; tracks line/pixel counts and overflow.
module win_capture
  import video_pkg::*;
#(
  parameter int PIX_W      = PIX_W_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync_start,
  input  logic             vref,
  input  logic             href,
  input  logic [PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0] m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             ovf,
  output logic [CNT_W-1:0] line_cnt,
  output logic [CNT_W-1:0] pix_cnt
);

  logic [1:0]       r_state;
  logic             r_vref_d;
  logic             r_hold_vld;
  logic             r_hold_sof;
  logic [PIX_W-1:0] r_hold_data;
  logic             r_sof_pend;
  logic [CNT_W-1:0] r_pix_run;
  logic [CNT_W-1:0] r_line_run;
  logic [CNT_W-1:0] r_line_cnt;
  logic [CNT_W-1:0] r_pix_cnt;
  logic             r_ovf;

  logic             w_qual;
  logic             w_vrise;
  logic             w_vfall;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_push_eol;
  logic             w_push_ok;
  logic             w_push_drop;
  logic [CNT_W-1:0] w_line_nxt;
  logic [PIX_W+1:0] w_rd_data;

  assign w_qual      = vref & href;
  assign w_vrise     = ~r_vref_d & vref;
  assign w_vfall     = r_vref_d & ~vref;
  assign w_pop       = ~w_empty & m_ready;
  // The held pixel leaves when the next one arrives, or ends the line otherwise.
  assign w_push      = vsync_start & (r_state == ST_FRAME) & r_hold_vld;
  assign w_push_eol  = ~w_qual;
  assign w_push_ok   = w_push & (~w_full | w_pop);
  assign w_push_drop = w_push & w_full & ~w_pop;
  assign w_line_nxt  = (w_push_ok & w_push_eol) ? sat_inc(r_line_run) : r_line_run;

  sync_fifo #(
    .WIDTH(PIX_W + 2),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (w_push_ok),
    .wr_data({r_hold_sof, w_push_eol, r_hold_data}),
    .rd_en  (w_pop),
    .rd_data(w_rd_data),
    .full   (w_full),
    .empty  (w_empty)
  );

  assign m_valid  = ~w_empty;
  assign m_sof    = w_rd_data[PIX_W+1];
  assign m_eol    = w_rd_data[PIX_W];
  assign m_data   = w_rd_data[PIX_W-1:0];
  assign ovf      = r_ovf;
  assign line_cnt = r_line_cnt;
  assign pix_cnt  = r_pix_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_vref_d    <= 1'b1;
      r_hold_vld  <= 1'b0;
      r_hold_sof  <= 1'b0;
      r_hold_data <= '0;
      r_sof_pend  <= 1'b0;
      r_pix_run   <= '0;
      r_line_run  <= '0;
      r_line_cnt  <= '0;
      r_pix_cnt   <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_vref_d <= vref;
      if (!vsync_start) begin
        r_state    <= ST_IDLE;
        r_hold_vld <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_WAIT_V;
          ST_WAIT_V: begin
            if (w_vrise) begin
              r_state    <= ST_FRAME;
              r_sof_pend <= 1'b1;
              r_line_run <= '0;
              r_pix_run  <= '0;
            end
          end
          ST_FRAME: begin
            if (w_push_drop) begin
              // A frame that overflowed never reports its line count.
              r_ovf      <= 1'b1;
              r_hold_vld <= 1'b0;
              r_state    <= w_vfall ? ST_WAIT_V : ST_DROP;
            end else begin
              if (w_qual) begin
                r_hold_vld  <= 1'b1;
                r_hold_data <= pix_in;
                r_hold_sof  <= r_sof_pend;
                r_sof_pend  <= 1'b0;
                r_pix_run   <= sat_inc(r_pix_run);
              end else begin
                r_hold_vld <= 1'b0;
              end
              if (w_push_ok && w_push_eol) begin
                r_pix_cnt  <= r_pix_run;
                r_pix_run  <= '0;
                r_line_run <= w_line_nxt;
              end
              if (w_vfall) begin
                r_line_cnt <= w_line_nxt;
                r_state    <= ST_WAIT_V;
              end
            end
          end
          ST_DROP: if (w_vfall) r_state <= ST_WAIT_V;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
